aurora_8b10b_0_link_reset_ctrl: RTL and testbench
=================================================

Name: aurora_8b10b_0_link_reset_ctrl

Overview:
Free-running reset sequencer and link watchdog on INIT_CLK_IN that drives the RESET and GT_RESET_IN inputs of the Aurora support reset logic. Issues a timed GT reset then system reset, waits for LANE_UP and CHANNEL_UP with timeouts, then monitors the live link. Re-initiates the full sequence on timeout, hard error, sustained CHANNEL_UP loss, or software request. Exposes link status and a retry counter to the IPbus register map.

Parameters:
GT_RST_CYCLES, 256, INIT_CLK cycles GT_RESET_OUT held high; must be >= 8 (debouncer needs 4 consecutive highs).
SYS_RST_CYCLES, 128, cycles SYSTEM_RESET_OUT held high after GT_RESET_OUT drops; >= 8.
LANE_TIMEOUT, 1000000, max cycles in WAIT_LANE before retry.
CHAN_TIMEOUT, 1000000, max cycles in WAIT_CHAN before retry.
DROP_FILTER, 16, consecutive cycles of synced CHANNEL_UP low in UP before retry; >= 1.
All cycle parameters must be < 2^24 (single shared 24-bit timer).

Ports:
INIT_CLK_IN  in  1  free-running clock; all logic on its rising edge
RESET  in  1  asynchronous, active-high reset
ENABLE  in  1  sync to INIT_CLK_IN; low holds link in reset
FORCE_RESET  in  1  sync single-cycle request to restart sequence
LANE_UP  in  1  async (USER_CLK domain); 2-flop synchronised internally
CHANNEL_UP  in  1  async; 2-flop synchronised internally
HARD_ERR  in  1  async; source holds it >= 2 INIT_CLK cycles; 2-flop synchronised
GT_RESET_OUT  out  1  to debouncer GT_RESET_IN
SYSTEM_RESET_OUT  out  1  to debouncer RESET
LINK_OK  out  1  high only in UP
RETRY_CNT  out  8  count of retries, saturating
STATE  out  3  current state encoding

Behaviour:
- States/encodings: DISABLED=0, GT_RST=1, SYS_RST=2, WAIT_LANE=3, WAIT_CHAN=4, UP=5; 6,7 unreachable, recover to GT_RST.
- All outputs registered, decoded from state: GT_RESET_OUT=1 in DISABLED, GT_RST; SYSTEM_RESET_OUT=1 in DISABLED, GT_RST, SYS_RST; LINK_OK=1 in UP only.
- Reset (async assert): state=GT_RST, timer=0, RETRY_CNT=0, GT_RESET_OUT=1, SYSTEM_RESET_OUT=1, LINK_OK=0, synchroniser flops=0. Mid-sequence reset aborts immediately to these values.
- Timer cleared on every state entry, increments each cycle in timed states.
- GT_RST: after GT_RST_CYCLES cycles (timer==GT_RST_CYCLES-1) -> SYS_RST.
- SYS_RST: after SYS_RST_CYCLES cycles -> WAIT_LANE.
- WAIT_LANE: lane_up_s=1 -> WAIT_CHAN; else timer==LANE_TIMEOUT-1 -> GT_RST, retry.
- WAIT_CHAN: chan_up_s=1 -> UP; lane_up_s=0 -> GT_RST, retry; timer==CHAN_TIMEOUT-1 -> GT_RST, retry.
- UP: drop counter increments while chan_up_s=0, clears when 1; reaching DROP_FILTER -> GT_RST, retry. hard_err_s=1 -> GT_RST, retry.
- FORCE_RESET=1 in any state except DISABLED -> GT_RST, retry (restarts timer even if already in GT_RST).
- ENABLE=0 in any state -> DISABLED (no retry). DISABLED, ENABLE=1 -> GT_RST (no retry).
- Priority per cycle: ENABLE low > FORCE_RESET > hard_err_s > drop/timeout > normal progression.
- Retry = RETRY_CNT+1, saturating at 255; cleared only by RESET.
- Input-to-decision latency: 2 cycles (synchroniser) + 1 (state register).

Test Plan:
(Params GT_RST_CYCLES=8, SYS_RST_CYCLES=8, LANE_TIMEOUT=32, CHAN_TIMEOUT=16, DROP_FILTER=3.)
1. Release RESET, ENABLE=1, raise LANE_UP then CHANNEL_UP -> GT_RESET_OUT high exactly 8 cycles, SYSTEM_RESET_OUT 16 cycles; LINK_OK=1, STATE=5, RETRY_CNT=0.
2. LANE_UP held 0 -> after 32 cycles in WAIT_LANE, return to STATE=1, RETRY_CNT=1; repeat 300 times -> RETRY_CNT saturates at 255.
3. In UP, CHANNEL_UP low 2 cycles then high -> stays UP; low 3 cycles -> GT_RST, RETRY_CNT+1, LINK_OK falls.
4. In UP, 2-cycle HARD_ERR pulse -> STATE=1 within 3 cycles, GT_RESET_OUT=1, RETRY_CNT+1.
5. ENABLE=0 mid-WAIT_CHAN with same-cycle FORCE_RESET -> STATE=0, both resets high, RETRY_CNT unchanged; ENABLE=1 -> STATE=1.
6. Assert RESET during SYS_RST -> outputs immediately GT_RESET_OUT=1, SYSTEM_RESET_OUT=1, RETRY_CNT=0; sequence restarts with full 8-cycle GT reset.

Source files
------------

// File: rtl/aurora_8b10b_0_link_reset_ctrl.sv
// aurora_8b10b_0_link_reset_ctrl: reset sequencer and link watchdog for the Aurora support reset logic
//   INIT_CLK_IN      free-running clock, all logic on its rising edge
//   RESET            asynchronous active-high reset
//   ENABLE           low holds the link in reset (DISABLED)
//   FORCE_RESET      single-cycle software request to restart the sequence
//   LANE_UP          lane status from USER_CLK domain, synchronised internally
//   CHANNEL_UP       channel status, synchronised internally
//   HARD_ERR         hard error, synchronised internally
//   GT_RESET_OUT     to debouncer GT_RESET_IN
//   SYSTEM_RESET_OUT to debouncer RESET
//   LINK_OK          high only while the link is up
//   RETRY_CNT        saturating count of retries, cleared only by RESET
//   STATE            current state encoding
module aurora_8b10b_0_link_reset_ctrl #(
    parameter int GT_RST_CYCLES  = 256,
    parameter int SYS_RST_CYCLES = 128,
    parameter int LANE_TIMEOUT   = 1000000,
    parameter int CHAN_TIMEOUT   = 1000000,
    parameter int DROP_FILTER    = 16
) (
    input  logic       INIT_CLK_IN,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       FORCE_RESET,
    input  logic       LANE_UP,
    input  logic       CHANNEL_UP,
    input  logic       HARD_ERR,
    output logic       GT_RESET_OUT,
    output logic       SYSTEM_RESET_OUT,
    output logic       LINK_OK,
    output logic [7:0] RETRY_CNT,
    output logic [2:0] STATE
);
    typedef enum logic [2:0] {
        DISABLED  = 3'd0,
        GT_RST    = 3'd1,
        SYS_RST   = 3'd2,
        WAIT_LANE = 3'd3,
        WAIT_CHAN = 3'd4,
        UP        = 3'd5
    } state_t;

    localparam logic [23:0] GT_LAST   = 24'(GT_RST_CYCLES - 1);
    localparam logic [23:0] SYS_LAST  = 24'(SYS_RST_CYCLES - 1);
    localparam logic [23:0] LANE_LAST = 24'(LANE_TIMEOUT - 1);
    localparam logic [23:0] CHAN_LAST = 24'(CHAN_TIMEOUT - 1);
    localparam logic [23:0] DROP_LAST = 24'(DROP_FILTER - 1);

    state_t      state, nxt;
    logic [23:0] timer, drop;
    logic [1:0]  lane_sync, chan_sync, herr_sync;
    logic        lane_up_s, chan_up_s, hard_err_s;
    logic        retry, restart, enter, timed;

    assign lane_up_s  = lane_sync[1];
    assign chan_up_s  = chan_sync[1];
    assign hard_err_s = herr_sync[1];
    assign STATE      = state;
    // A forced restart re-enters GT_RST even when already there, so the timer must clear.
    assign enter      = restart || (nxt != state);
    assign timed      = (state == GT_RST) || (state == SYS_RST) ||
                        (state == WAIT_LANE) || (state == WAIT_CHAN);

    always_comb begin
        nxt     = state;
        retry   = 1'b0;
        restart = 1'b0;
        if (!ENABLE)
            nxt = DISABLED;
        else if (state == DISABLED)
            nxt = GT_RST;
        else if (FORCE_RESET) begin
            nxt     = GT_RST;
            retry   = 1'b1;
            restart = 1'b1;
        end else begin
            case (state)
                GT_RST:    nxt = (timer == GT_LAST) ? SYS_RST : GT_RST;
                SYS_RST:   nxt = (timer == SYS_LAST) ? WAIT_LANE : SYS_RST;
                WAIT_LANE: begin
                    if (lane_up_s)
                        nxt = WAIT_CHAN;
                    else if (timer == LANE_LAST) begin
                        nxt   = GT_RST;
                        retry = 1'b1;
                    end
                end
                WAIT_CHAN: begin
                    if (chan_up_s)
                        nxt = UP;
                    else if (!lane_up_s || timer == CHAN_LAST) begin
                        nxt   = GT_RST;
                        retry = 1'b1;
                    end
                end
                UP: begin
                    // drop holds the number of consecutive low cycles already seen
                    if (hard_err_s || (!chan_up_s && drop == DROP_LAST)) begin
                        nxt   = GT_RST;
                        retry = 1'b1;
                    end
                end
                default:   nxt = GT_RST;
            endcase
        end
    end

    always_ff @(posedge INIT_CLK_IN or posedge RESET) begin
        if (RESET) begin
            state            <= GT_RST;
            timer            <= '0;
            drop             <= '0;
            RETRY_CNT        <= '0;
            GT_RESET_OUT     <= 1'b1;
            SYSTEM_RESET_OUT <= 1'b1;
            LINK_OK          <= 1'b0;
            lane_sync        <= '0;
            chan_sync        <= '0;
            herr_sync        <= '0;
        end else begin
            lane_sync        <= {lane_sync[0], LANE_UP};
            chan_sync        <= {chan_sync[0], CHANNEL_UP};
            herr_sync        <= {herr_sync[0], HARD_ERR};
            state            <= nxt;
            timer            <= enter ? '0 : (timed ? timer + 24'd1 : timer);
            drop             <= (enter || chan_up_s) ? '0 : drop + 24'd1;
            RETRY_CNT        <= (retry && RETRY_CNT != 8'hFF) ? RETRY_CNT + 8'd1 : RETRY_CNT;
            GT_RESET_OUT     <= (nxt == DISABLED) || (nxt == GT_RST);
            SYSTEM_RESET_OUT <= (nxt == DISABLED) || (nxt == GT_RST) || (nxt == SYS_RST);
            LINK_OK          <= (nxt == UP);
        end
    end
endmodule

// File: tb/tb_aurora_8b10b_0_link_reset_ctrl.sv
// tb_aurora_8b10b_0_link_reset_ctrl: directed scoreboard bench for the link reset controller
module tb_aurora_8b10b_0_link_reset_ctrl;
    logic       INIT_CLK_IN = 1'b0;
    logic       RESET = 1'b0;
    logic       ENABLE = 1'b1;
    logic       FORCE_RESET = 1'b0;
    logic       LANE_UP = 1'b0;
    logic       CHANNEL_UP = 1'b0;
    logic       HARD_ERR = 1'b0;
    logic       GT_RESET_OUT, SYSTEM_RESET_OUT, LINK_OK;
    logic [7:0] RETRY_CNT;
    logic [2:0] STATE;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    aurora_8b10b_0_link_reset_ctrl #(
        .GT_RST_CYCLES(8), .SYS_RST_CYCLES(8), .LANE_TIMEOUT(32),
        .CHAN_TIMEOUT(16), .DROP_FILTER(3)
    ) dut (
        .INIT_CLK_IN(INIT_CLK_IN), .RESET(RESET), .ENABLE(ENABLE),
        .FORCE_RESET(FORCE_RESET), .LANE_UP(LANE_UP), .CHANNEL_UP(CHANNEL_UP),
        .HARD_ERR(HARD_ERR), .GT_RESET_OUT(GT_RESET_OUT),
        .SYSTEM_RESET_OUT(SYSTEM_RESET_OUT), .LINK_OK(LINK_OK),
        .RETRY_CNT(RETRY_CNT), .STATE(STATE)
    );

    always #5 INIT_CLK_IN = ~INIT_CLK_IN;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge INIT_CLK_IN);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (STATE === s) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic measure(output int g, output int s);
        g = -1;
        s = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (g < 0 && GT_RESET_OUT === 1'b0) g = i;
            if (SYSTEM_RESET_OUT === 1'b0) begin
                s = i;
                break;
            end
        end
    endtask

    task automatic status(input string tag, input logic [2:0] st, input logic gt,
                          input logic sys, input logic ok, input logic [7:0] rc);
        push({tag, "_state"}, 32'(st));      check(32'(STATE));
        push({tag, "_gt"}, 32'(gt));         check(32'(GT_RESET_OUT));
        push({tag, "_sys"}, 32'(sys));       check(32'(SYSTEM_RESET_OUT));
        push({tag, "_link"}, 32'(ok));       check(32'(LINK_OK));
        push({tag, "_retry"}, 32'(rc));      check(32'(RETRY_CNT));
    endtask

    initial begin
        int n, g, s, bad;
        #2 RESET = 1'b1;
        repeat (3) tick();
        status("reset", 3'd1, 1'b1, 1'b1, 1'b0, 8'd0);
        RESET = 1'b0;
        push("gt_high_cycles", 8);
        push("sys_high_cycles", 16);
        measure(g, s);
        check(32'(g));
        check(32'(s));
        push("wait_lane_state", 3); check(32'(STATE));
        LANE_UP = 1'b1;
        push("lane_latency", 3);
        wait_state(3'd4, 10, n); check(32'(n));
        CHANNEL_UP = 1'b1;
        push("chan_latency", 3);
        wait_state(3'd5, 10, n); check(32'(n));
        status("up", 3'd5, 1'b0, 1'b0, 1'b1, 8'd0);

        CHANNEL_UP = 1'b0;
        repeat (2) tick();
        CHANNEL_UP = 1'b1;
        repeat (6) tick();
        status("glitch", 3'd5, 1'b0, 1'b0, 1'b1, 8'd0);
        CHANNEL_UP = 1'b0;
        push("drop_latency", 5);
        wait_state(3'd1, 20, n); check(32'(n));
        status("drop", 3'd1, 1'b1, 1'b1, 1'b0, 8'd1);
        CHANNEL_UP = 1'b1;
        push("relink_cycles", 18);
        wait_state(3'd5, 40, n); check(32'(n));

        HARD_ERR = 1'b1;
        repeat (2) tick();
        HARD_ERR = 1'b0;
        push("herr_latency", 1);
        wait_state(3'd1, 10, n); check(32'(n));
        status("herr", 3'd1, 1'b1, 1'b1, 1'b0, 8'd2);

        CHANNEL_UP = 1'b0;
        push("to_wait_chan", 17);
        wait_state(3'd4, 40, n); check(32'(n));
        repeat (2) tick();
        ENABLE = 1'b0;
        FORCE_RESET = 1'b1;
        tick();
        FORCE_RESET = 1'b0;
        status("disabled", 3'd0, 1'b1, 1'b1, 1'b0, 8'd2);
        ENABLE = 1'b1;
        tick();
        status("enabled", 3'd1, 1'b1, 1'b1, 1'b0, 8'd2);
        repeat (4) tick();
        FORCE_RESET = 1'b1;
        tick();
        FORCE_RESET = 1'b0;
        push("force_retry", 3); check(32'(RETRY_CNT));
        push("force_restart_gt", 8);
        wait_state(3'd2, 20, n); check(32'(n));

        repeat (3) tick();
        RESET = 1'b1;
        #1;
        status("midreset", 3'd1, 1'b1, 1'b1, 1'b0, 8'd0);
        LANE_UP = 1'b0;
        repeat (2) tick();
        RESET = 1'b0;
        push("gt_high_after_reset", 8);
        push("sys_high_after_reset", 16);
        measure(g, s);
        check(32'(g));
        check(32'(s));
        push("lane_timeout", 32);
        wait_state(3'd1, 50, n); check(32'(n));
        push("timeout_retry", 1); check(32'(RETRY_CNT));

        bad = 0;
        for (int i = 0; i < 260; i++) begin
            wait_state(3'd3, 30, n);
            if (n != 16) bad++;
            wait_state(3'd1, 40, n);
            if (n != 32) bad++;
        end
        push("retry_period_errors", 0); check(32'(bad));
        push("retry_saturated", 255);   check(32'(RETRY_CNT));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
